// File: rtl/dmem_access_unit_pkg.sv
// Shared operation types for the data-memory access path: splice width
// encoding, access-unit state enum and lane alignment helpers.
package dmem_access_unit_pkg;

  typedef enum logic [1:0] {
    SPL_DWORD = 2'b00,
    SPL_WORD  = 2'b01,
    SPL_HALF  = 2'b10,
    SPL_BYTE  = 2'b11
  } splice_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dau_state_e;

  // Byte offset of the lane, with offset bits below the lane width dropped.
  function automatic logic [2:0] lane_offset(input splice_e spl, input logic [2:0] off);
    logic [2:0] res;
    case (spl)
      SPL_DWORD: res = 3'b000;
      SPL_WORD:  res = {off[2], 2'b00};
      SPL_HALF:  res = {off[2:1], 1'b0};
      SPL_BYTE:  res = off;
      default:   res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic is_aligned(input splice_e spl, input logic [2:0] off);
    logic res;
    case (spl)
      SPL_DWORD: res = (off == 3'b000);
      SPL_WORD:  res = (off[1:0] == 2'b00);
      SPL_HALF:  res = (off[0] == 1'b0);
      SPL_BYTE:  res = 1'b1;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane_splicer.sv
// Combinational lane extract/extend (loads) and lane merge (sub-dword stores)
// on a little-endian doubleword.
module dmem_lane_splicer
  import dmem_access_unit_pkg::*;
(
  input  splice_e     splice,
  input  logic [2:0]  offset,
  input  logic [63:0] dword_in,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged_data
);

  logic [5:0]  shamt_s;
  logic [63:0] shifted_s;
  logic [63:0] lane_mask_s;

  // Select the lane, extend it for loads and splice wdata into it for stores.
  always_comb begin
    shamt_s     = {lane_offset(splice, offset), 3'b000};
    shifted_s   = dword_in >> shamt_s;
    load_data   = dword_in;
    lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
    case (splice)
      SPL_DWORD: begin
        load_data   = dword_in;
        lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      SPL_WORD: begin
        load_data   = {{32{shifted_s[31]}}, shifted_s[31:0]};
        lane_mask_s = 64'h0000_0000_FFFF_FFFF;
      end
      SPL_HALF: begin
        load_data   = {{48{shifted_s[15]}}, shifted_s[15:0]};
        lane_mask_s = 64'h0000_0000_0000_FFFF;
      end
      SPL_BYTE: begin
        // Byte loads are the unsigned form (LBU).
        load_data   = {56'd0, shifted_s[7:0]};
        lane_mask_s = 64'h0000_0000_0000_00FF;
      end
      default: begin
        load_data   = dword_in;
        lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
    merged_data = (dword_in & ~(lane_mask_s << shamt_s)) | ((wdata & lane_mask_s) << shamt_s);
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: loads and read-modify-write sub-dword stores over a
// doubleword memory port. Optional misalignment trap: define MISALIGN_TRAP_EN.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  splice,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [63:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
`ifdef MISALIGN_TRAP_EN
  output logic        fault,
`endif
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);

  dau_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  splice_e     splice_q, splice_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] buf_q, buf_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [63:0] lane_src_s, load_data_s, merged_s;
`ifdef MISALIGN_TRAP_EN
  logic        fault_q, fault_d;
`endif

  // The buffer holds read data in MERGE; otherwise the splicer sees the bus.
  assign lane_src_s = (state_q == ST_MERGE) ? buf_q : mem_rdata;

  dmem_lane_splicer u_splicer (
    .splice      (splice_q),
    .offset      (off_q),
    .dword_in    (lane_src_s),
    .wdata       (wdata_q),
    .load_data   (load_data_s),
    .merged_data (merged_s)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    splice_d   = splice_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
`ifdef MISALIGN_TRAP_EN
    fault_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          splice_d   = splice_e'(splice);
          off_d      = addr[2:0];
          wdata_d    = wdata;
          mem_addr_d = {addr[63:3], 3'b000};
`ifdef MISALIGN_TRAP_EN
          if (!is_aligned(splice_e'(splice), addr[2:0])) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else
`endif
          if (is_store && (splice_e'(splice) == SPL_DWORD)) begin
            state_d = ST_WRITE;
            buf_d   = wdata;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (mem_ack && mem_req_q) begin
          buf_d = mem_rdata;
          if (is_store_q) begin
            state_d = ST_MERGE;
          end else begin
            state_d = ST_DONE;
            rdata_d = load_data_s;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_MERGE: begin
        buf_d   = merged_s;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (mem_ack && mem_req_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    mem_req_d = (state_d == ST_READ) || (state_d == ST_WRITE);
    mem_we_d  = (state_d == ST_WRITE);
    if (state_d == ST_WRITE) begin
      mem_wdata_d = buf_d;
    end else begin
      mem_wdata_d = mem_wdata_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      is_store_q  <= 1'b0;
      splice_q    <= SPL_DWORD;
      off_q       <= 3'b000;
      wdata_q     <= 64'd0;
      buf_q       <= 64'd0;
      rdata_q     <= 64'd0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      splice_q    <= splice_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
`ifdef MISALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef MISALIGN_TRAP_EN
  assign fault     = fault_q;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench for dmem_access_unit against a byte-addressed reference
// memory model; honours MISALIGN_TRAP_EN when defined.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset, start, is_store, mem_ack;
  logic [1:0]  splice;
  logic [63:0] addr, wdata, mem_rdata;
  logic        busy, done, mem_req, mem_we;
  logic [63:0] rdata, mem_addr, mem_wdata;
`ifdef MISALIGN_TRAP_EN
  logic        fault;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  ref_mem [0:1023];
  logic [63:0] dut_mem [0:127];
  logic [63:0] exp_rdata;

  dmem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .splice    (splice),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef MISALIGN_TRAP_EN
    .fault     (fault),
`endif
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  task automatic set_dword(input int idx, input logic [63:0] v);
    dut_mem[idx] = v;
    for (int k = 0; k < 8; k++) ref_mem[idx*8 + k] = v[8*k +: 8];
  endtask

  function automatic logic [63:0] ref_dword(input int idx);
    logic [63:0] v = 64'd0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = ref_mem[idx*8 + k];
    return v;
  endfunction

  // One access: update the reference model, drive the DUT, act as memory.
  task automatic do_op(input logic st, input logic [1:0] spl, input logic [63:0] a,
                       input logic [63:0] wd, input int lat, input logic junk);
    int nb, off, idx, exp_cyc, done_cyc, req_age, req_rises, writes;
    logic trap;
    logic [63:0] v;
    nb   = 8 >> spl;
    idx  = int'(a[9:3]);
    off  = (int'(a[2:0]) / nb) * nb;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (int'(a[2:0]) % nb) != 0;
`endif
    if (trap) exp_cyc = 1;
    else if (st && spl != 2'b00) exp_cyc = 2*lat + 4;
    else exp_cyc = lat + 2;
    if (!trap) begin
      if (st) begin
        for (int k = 0; k < nb; k++) ref_mem[idx*8 + off + k] = wd[8*k +: 8];
      end else begin
        v = 64'd0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[idx*8 + off + k];
        case (nb)
          4:       exp_rdata = {{32{v[31]}}, v[31:0]};
          2:       exp_rdata = {{48{v[15]}}, v[15:0]};
          default: exp_rdata = v;
        endcase
      end
    end

    @(negedge clk);
    start = 1'b1; is_store = st; splice = spl; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    done_cyc = 0; req_age = 0; req_rises = 0; writes = 0;
    for (int n = 1; n <= 100; n++) begin
      if (done_cyc != 0) begin
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
        break;
      end
      if (n == 1)
        check("cycle1_req_we", {62'd0, mem_req, mem_we},
              trap ? 64'd0 : ((st && spl == 2'b00) ? 64'd3 : 64'd2));
      if (done) begin
        done_cyc = n;
`ifdef MISALIGN_TRAP_EN
        check("fault_with_done", {63'd0, fault}, {63'd0, trap});
`endif
      end
      if (mem_req) begin
        if (req_age == 0) begin
          req_rises++;
          check("mem_addr", mem_addr, {a[63:3], 3'b000});
        end
        if (req_age >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            dut_mem[idx] = mem_wdata;
            writes++;
          end else begin
            mem_rdata = dut_mem[idx];
          end
        end else begin
          mem_ack = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
        req_age++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom};
        req_age = 0;
      end
      if (junk && busy && !done) begin
        start = 1'($urandom_range(0, 1)); is_store = 1'($urandom_range(0, 1));
        splice = 2'($urandom_range(0, 3)); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0; start = 1'b0;
    check("done_latency", 64'(done_cyc), 64'(exp_cyc));
    check("req_count", 64'(req_rises), trap ? 64'd0 : ((st && spl != 2'b00) ? 64'd2 : 64'd1));
    check("write_count", 64'(writes), (st && !trap) ? 64'd1 : 64'd0);
    check("rdata", rdata, exp_rdata);
    check("mem_dword", dut_mem[idx], ref_dword(idx));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; is_store = 1'b0; splice = 2'b00;
    addr = 64'd0; wdata = 64'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
    exp_rdata = 64'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {60'd0, busy, done, mem_req, mem_we}, 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 128; i++) set_dword(i, {$urandom, $urandom});

    // Load word, sign-extended, ack after two cycles.
    set_dword(32, 64'h8000_0001_0000_0000);
    do_op(1'b0, 2'b01, 64'h104, 64'd0, 2, 1'b0);
    check("lw_0x104", rdata, 64'hFFFF_FFFF_8000_0001);

    // Store byte read-modify-write.
    set_dword(64, 64'h1122_3344_5566_7788);
    do_op(1'b1, 2'b11, 64'h203, 64'h0000_0000_0000_00AB, 1, 1'b0);
    check("sb_0x203", dut_mem[64], 64'h1122_3344_AB66_7788);

    // Dword store with zero-latency ack.
    do_op(1'b1, 2'b00, 64'h3F8, 64'hDEAD_BEEF_0123_4567, 0, 1'b0);

    // LBU at offset 7 with start pulsed while busy.
    set_dword(2, 64'hF0AA_5555_1234_5678);
    do_op(1'b0, 2'b11, 64'h17, 64'd0, 1, 1'b1);
    check("lbu_0x17", rdata, 64'h0000_0000_0000_00F0);

`ifdef MISALIGN_TRAP_EN
    do_op(1'b0, 2'b01, 64'h102, 64'd0, 0, 1'b0);
`endif

    // Reset during WRITE with ack withheld.
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; splice = 2'b00; addr = 64'h80; wdata = 64'h5A5A_5A5A_5A5A_5A5A;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
    check("rst_mid_write_req", {62'd0, mem_req, mem_we}, 64'd3);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {60'd0, busy, done, mem_req, mem_we}, 64'd0);
    check("rst_mid_rdata", rdata, 64'd0);
    reset = 1'b1;
    exp_rdata = 64'd0;
    @(negedge clk);
    check("rst_mid_no_done", {62'd0, busy, done}, 64'd0);
    check("rst_mid_mem", dut_mem[16], ref_dword(16));

    for (int i = 0; i < 60; i++) begin
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            {32'($urandom), 22'd0, 10'($urandom_range(0, 1023))},
            {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
